// File: rtl/step_input_conditioner.sv
// ---------------------------------------------------------------------------
// step_input_conditioner
//
// Front end for the Moore-automaton lab cores. It turns raw board inputs
// into a clean one-cycle step strobe (en) and a debounced data level (a).
//
//   raw btn_step --> 2-flop sync --> debounce --> press-edge --+
//                                                              +--> en --> step_cnt
//   raw sw_auto  --> 2-flop sync --> auto_on --> prescaler ----+
//   raw sw_a     --> 2-flop sync --> debounce --> a
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   btn_step  in   raw step pushbutton, asynchronous, 1 = pressed
//   sw_a      in   raw data switch, asynchronous
//   sw_auto   in   raw auto-run switch, asynchronous, 1 = auto stepping
//   en        out  one-cycle step strobe to the automaton (registered)
//   a         out  debounced data level to the automaton (registered)
//   step_cnt  out  number of en pulses issued, wraps at 2^CNT_W
//   auto_on   out  synchronised sw_auto, for the status LED
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive disagreeing synchronised samples needed to
//                    accept a new level on btn_step / sw_a (>= 1)
//   AUTO_PERIOD      clk cycles between auto-mode step pulses (>= 2)
//   CNT_W            width of step_cnt
// ---------------------------------------------------------------------------
module step_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_PERIOD     = 5,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_step,
    input  logic             sw_a,
    input  logic             sw_auto,
    output logic             en,
    output logic             a,
    output logic [CNT_W-1:0] step_cnt,
    output logic             auto_on
);

    // Bit positions inside the synchroniser vectors.
    localparam int IDX_BTN  = 0;
    localparam int IDX_DAT  = 1;
    localparam int IDX_AUTO = 2;

    localparam int                DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int                PS_W    = $clog2(AUTO_PERIOD);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0]   PS_LAST = PS_W'(AUTO_PERIOD - 1);

    // Synchronisers for all three raw inputs: {sw_auto, sw_a, btn_step}.
    logic [2:0]            sync1;
    logic [2:0]            sync2;

    // Debouncers: index IDX_BTN for the button, IDX_DAT for the data switch.
    logic [1:0]            db_stable;
    logic [1:0][DB_W-1:0]  db_cnt;
    logic [1:0]            db_stable_nx;
    logic [1:0][DB_W-1:0]  db_cnt_nx;
    logic [1:0]            db_accept;

    logic [PS_W-1:0]       presc;
    logic [PS_W-1:0]       presc_nx;

    logic                  press;
    logic                  presc_wrap;
    logic                  manual_mode;
    logic                  auto_mode;
    logic                  en_nx;

    assign auto_on = sync2[IDX_AUTO];
    assign a       = db_stable[IDX_DAT];

    // -----------------------------------------------------------------------
    // Debounce next-state. A disagreement must persist for DEBOUNCE_CYCLES
    // consecutive samples; any agreeing sample restarts the count from 0.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        db_stable_nx = db_stable;
        db_cnt_nx    = '0;
        db_accept    = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2[i] != db_stable[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    db_stable_nx[i] = sync2[i];
                    db_accept[i]    = 1'b1;
                end else begin
                    db_cnt_nx[i] = db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Step strobe generation.
    //
    // The press edge is taken from the debouncer's next state so that en is
    // set on the same edge at which the stable button level rises.
    //
    // Mode selection looks at both the current auto_on (sync2) and the value
    // it takes at this edge (sync1). A mode change at this edge therefore
    // suppresses both pulse sources: a press coinciding with auto_on rising
    // is dropped, and so is a prescaler wrap coinciding with auto_on falling.
    // -----------------------------------------------------------------------
    always_comb begin
        press       = db_accept[IDX_BTN] & sync2[IDX_BTN];
        presc_wrap  = (presc == PS_LAST);
        manual_mode = ~sync2[IDX_AUTO] & ~sync1[IDX_AUTO];
        auto_mode   =  sync2[IDX_AUTO] &  sync1[IDX_AUTO];

        // Prescaler is parked at 0 outside auto mode, so the first auto
        // pulse lands AUTO_PERIOD cycles after auto_on rises.
        presc_nx = '0;
        if (sync2[IDX_AUTO] && !presc_wrap) begin
            presc_nx = presc + 1'b1;
        end

        en_nx = (manual_mode & press) | (auto_mode & presc_wrap);
    end

    // -----------------------------------------------------------------------
    // State registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, e.g. sync2 takes the old sync1.
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            db_stable <= '0;
            db_cnt    <= '0;
            presc     <= '0;
            en        <= 1'b0;
            step_cnt  <= '0;
        end else begin
            sync1     <= {sw_auto, sw_a, btn_step};
            sync2     <= sync1;
            db_stable <= db_stable_nx;
            db_cnt    <= db_cnt_nx;
            presc     <= presc_nx;
            en        <= en_nx;
            step_cnt  <= step_cnt + CNT_W'(en_nx);
        end
    end

endmodule

// File: tb/tb_step_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_step_input_conditioner
//
// Self-checking bench for step_input_conditioner (D=4, AUTO_PERIOD=5,
// CNT_W=8). Inputs change on the falling edge; outputs are sampled on the
// falling edge that follows each rising edge.
//   - table of per-cycle vectors: glitch rejection, single press, bouncy sw_a
//   - hand sequences: auto mode, step_cnt wrap, reset mid-debounce
//   - random stimulus against a behavioural model built from input history
// ---------------------------------------------------------------------------
module tb_step_input_conditioner;

    localparam int D  = 4;
    localparam int P  = 5;
    localparam int W  = 8;
    localparam int NV = 54;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         btn_step;
    logic         sw_a;
    logic         sw_auto;
    logic         en;
    logic         a;
    logic [W-1:0] step_cnt;
    logic         auto_on;

    int tests = 0;
    int fails = 0;

    step_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .AUTO_PERIOD     (P),
        .CNT_W           (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_step (btn_step),
        .sw_a     (sw_a),
        .sw_auto  (sw_auto),
        .en       (en),
        .a        (a),
        .step_cnt (step_cnt),
        .auto_on  (auto_on)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model. It remembers every raw input sampled since the last
    // reset (index n = n-th rising edge) and derives the outputs from that
    // history: the synchronised value seen at edge n is the raw sample of
    // edge n-2, a stable level flips once the last D seen samples all
    // disagree with it, and auto pulses fall on every P-th consecutive edge
    // with auto_on high.
    // -----------------------------------------------------------------------
    bit hb[$];
    bit ha[$];
    bit hu[$];
    int n;
    bit m_sb, m_sa, m_en, m_auto;
    int m_run;
    int m_cnt;
    bit compare_model;

    function automatic bit hist(input int which, input int idx);
        if (idx < 0) return 1'b0;
        case (which)
            0:       return hb[idx];
            1:       return ha[idx];
            default: return hu[idx];
        endcase
    endfunction

    function automatic bit all_differ(input int which, input bit level);
        for (int j = 0; j < D; j++)
            if (hist(which, n - 2 - j) == level) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        hb.delete(); ha.delete(); hu.delete();
        n = 0; m_sb = 0; m_sa = 0; m_en = 0; m_auto = 0; m_run = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit flip_b, flip_a, auto_before, auto_next, rise, pulse;
        flip_b      = all_differ(0, m_sb);
        flip_a      = all_differ(1, m_sa);
        auto_before = hist(2, n - 2);
        auto_next   = hist(2, n - 1);
        rise        = flip_b && !m_sb;
        m_run       = auto_before ? m_run + 1 : 0;
        pulse       = (auto_before && auto_next && (m_run % P == 0)) ||
                      (!auto_before && !auto_next && rise);
        m_en        = pulse;
        m_cnt       = (m_cnt + (pulse ? 1 : 0)) % (1 << W);
        if (flip_b) m_sb = !m_sb;
        if (flip_a) m_sa = !m_sa;
        m_auto      = hist(2, n - 1);
        n++;
    endtask

    // One clock: record inputs, rising edge, update model, sample at fall.
    task automatic tick();
        hb.push_back(btn_step);
        ha.push_back(sw_a);
        hu.push_back(sw_auto);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (compare_model) begin
            check($sformatf("rnd%0d en", n), int'(en), int'(m_en));
            check($sformatf("rnd%0d a", n), int'(a), int'(m_sa));
            check($sformatf("rnd%0d step_cnt", n), int'(step_cnt), m_cnt);
            check($sformatf("rnd%0d auto_on", n), int'(auto_on), int'(m_auto));
        end
    endtask

    // Called on a falling edge; leaves the bench on a falling edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Button held 7 cycles, then released 7 cycles; returns pulses seen.
    task automatic press(output int pulses);
        pulses = 0;
        for (int t = 0; t < 14; t++) begin
            btn_step = (t < 7);
            tick();
            if (en) pulses++;
        end
    endtask

    typedef struct {
        bit btn;
        bit swa;
        bit en;
        bit a;
        int cnt;
    } vec_t;

    vec_t vecs[NV];

    initial begin
        int pulses;
        int total;

        // Vector i is applied before rising edge i+1 after reset release.
        //   0..2   : 3-cycle button glitch, rejected
        //   12..31 : held press, raw rise at edge 13 -> en after edge 18
        //   42..   : sw_a bounces 1,0,1 then steady; a rises after edge 50
        for (int i = 0; i < NV; i++) begin
            vecs[i].btn = (i < 3) || (i >= 12 && i < 32);
            vecs[i].swa = (i == 42) || (i >= 44);
            vecs[i].en  = (i == 17);
            vecs[i].a   = (i >= 49);
            vecs[i].cnt = (i >= 17) ? 1 : 0;
        end

        compare_model = 1'b0;
        btn_step = 1'b0; sw_a = 1'b0; sw_auto = 1'b0;
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        check("reset en", int'(en), 0);
        check("reset a", int'(a), 0);
        check("reset step_cnt", int'(step_cnt), 0);
        check("reset auto_on", int'(auto_on), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < NV; i++) begin
            btn_step = vecs[i].btn;
            sw_a     = vecs[i].swa;
            tick();
            check($sformatf("vec%0d en", i), int'(en), int'(vecs[i].en));
            check($sformatf("vec%0d a", i), int'(a), int'(vecs[i].a));
            check($sformatf("vec%0d step_cnt", i), int'(step_cnt), vecs[i].cnt);
        end

        // Auto mode: sw_auto high for 23 cycles, button pressed mid-run.
        // Pulses after edges 7, 12, 17, 22; auto_on high after edges 2..24.
        for (int t = 1; t <= 33; t++) begin
            sw_auto  = (t <= 23);
            btn_step = (t >= 9 && t <= 14);
            tick();
            check($sformatf("auto t%0d en", t), int'(en),
                  int'(t == 7 || t == 12 || t == 17 || t == 22));
            check($sformatf("auto t%0d auto_on", t), int'(auto_on),
                  int'(t >= 2 && t <= 24));
        end
        check("auto step_cnt", int'(step_cnt), 5);

        // step_cnt wrap: 255 presses, then one more.
        apply_reset();
        total = 0;
        for (int p = 0; p < 255; p++) begin
            press(pulses);
            total += pulses;
        end
        check("wrap presses", total, 255);
        check("wrap preload", int'(step_cnt), 255);
        press(pulses);
        check("wrap last pulse", pulses, 1);
        check("wrap step_cnt", int'(step_cnt), 0);

        // Reset two cycles into a debounce with the button held.
        apply_reset();
        sw_a = 1'b1;
        press(pulses);
        check("pre-reset a", int'(a), 1);
        check("pre-reset step_cnt", int'(step_cnt), 1);
        btn_step = 1'b1;
        repeat (4) tick();
        check("mid-debounce en", int'(en), 0);
        rst_n = 1'b0;
        #1;
        check("in-reset en", int'(en), 0);
        check("in-reset a", int'(a), 0);
        check("in-reset step_cnt", int'(step_cnt), 0);
        repeat (2) @(negedge clk);
        check("end-reset step_cnt", int'(step_cnt), 0);
        rst_n = 1'b1;
        model_clear();
        for (int t = 1; t <= 12; t++) begin
            tick();
            check($sformatf("post-reset t%0d en", t), int'(en), int'(t == 6));
            check($sformatf("post-reset t%0d a", t), int'(a), int'(t >= 6));
        end
        check("post-reset step_cnt", int'(step_cnt), 1);

        // Random stimulus against the model, with occasional resets.
        btn_step = 1'b0; sw_a = 1'b0; sw_auto = 1'b0;
        apply_reset();
        compare_model = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0)  btn_step = ~btn_step;
            if ($urandom_range(0, 7) == 0)  sw_a     = ~sw_a;
            if ($urandom_range(0, 59) == 0) sw_auto  = ~sw_auto;
            if ($urandom_range(0, 699) == 0) begin
                rst_n = 1'b0;
                #1;
                check("rnd reset en", int'(en), 0);
                check("rnd reset step_cnt", int'(step_cnt), 0);
                @(negedge clk);
                apply_reset();
            end
            tick();
        end
        compare_model = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
